pwm_cfg_arbiter: RTL and testbench

//  Arbitrates PWM parameter updates from REQ_NUM independent sources (UDP pwm_config

---
 rtl/pwm_cfg_arbiter_pkg.sv | 12 +
 rtl/pwm_rr_arbiter.sv | 30 +++
 rtl/pwm_cfg_arbiter.sv | 134 +++++++++++++
 tb/tb_pwm_cfg_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_cfg_arbiter_pkg.sv
// rtl/pwm_cfg_arbiter_pkg.sv - shared widths and FSM encoding for the PWM config arbiter
package pwm_cfg_arbiter_pkg;

    localparam int PWM_CH_W  = 8;
    localparam int PWM_CNT_W = 28;

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_SWEEP = 1'b1
    } arb_state_t;

endpackage

// File: rtl/pwm_rr_arbiter.sv
// rtl/pwm_rr_arbiter.sv - round-robin grant: first requester at or above ptr, wrapping
module pwm_rr_arbiter #(
    parameter int REQ_NUM = 2,
    parameter int PTR_W   = 1
) (
    input  logic [REQ_NUM-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [REQ_NUM-1:0] grant,
    output logic [PTR_W-1:0]   winner
);

    logic             found;
    logic [PTR_W-1:0] idx;

    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            idx = PTR_W'((int'(ptr) + i) % REQ_NUM);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                winner     = idx;
            end
        end
    end

endmodule

// File: rtl/pwm_cfg_arbiter.sv
// rtl/pwm_cfg_arbiter.sv - arbitrates PWM config updates onto one bus, with watchdog failsafe sweep
module pwm_cfg_arbiter
    import pwm_cfg_arbiter_pkg::*;
#(
    parameter int REQ_NUM     = 2,
    parameter int PWM_NUM     = 1,
    parameter int TIMEOUT_CYC = 100000000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [REQ_NUM-1:0]            req_vld,
    output logic [REQ_NUM-1:0]            req_rdy,
    input  logic [PWM_CH_W*REQ_NUM-1:0]   req_channel,
    input  logic [REQ_NUM-1:0]            req_en,
    input  logic [PWM_CNT_W*REQ_NUM-1:0]  req_period,
    input  logic [PWM_CNT_W*REQ_NUM-1:0]  req_hlevel,
    output logic                          pwm_config_vld,
    output logic [PWM_CH_W-1:0]           pwm_config_channel,
    output logic                          pwm_en,
    output logic [PWM_CNT_W-1:0]          pwm_period,
    output logic [PWM_CNT_W-1:0]          pwm_hlevel,
    output logic                          failsafe_active
);

    localparam int PTR_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
    localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam bit WDOG_ON = (TIMEOUT_CYC != 0);
    localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [PTR_W-1:0]    PTR_LAST   = PTR_W'(REQ_NUM - 1);
    localparam logic [PWM_CH_W-1:0] SWEEP_LAST = PWM_CH_W'(PWM_NUM - 1);

    arb_state_t             state_q, state_d;
    logic [PTR_W-1:0]       ptr_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [PWM_CH_W-1:0]    sweep_idx_q;
    logic [REQ_NUM-1:0]     grant;
    logic [PTR_W-1:0]       winner;
    logic                   accept;
    logic                   expire;

    pwm_rr_arbiter #(
        .REQ_NUM (REQ_NUM),
        .PTR_W   (PTR_W)
    ) u_rr (
        .req    (req_vld),
        .ptr    (ptr_q),
        .grant  (grant),
        .winner (winner)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_ARB;
        end else begin
            state_q <= state_d;
        end
    end

    // An accept in the same cycle as the last watchdog count suppresses the expiry.
    always_comb begin
        state_d = state_q;
        req_rdy = '0;
        accept  = 1'b0;
        expire  = 1'b0;
        case (state_q)
            ST_ARB: begin
                req_rdy = grant;
                accept  = |req_vld;
                expire  = WDOG_ON && !failsafe_active && !accept && (cnt_q == CNT_LAST);
                if (expire) begin
                    state_d = ST_SWEEP;
                end
            end
            ST_SWEEP: begin
                if (sweep_idx_q == SWEEP_LAST) begin
                    state_d = ST_ARB;
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q           <= '0;
            cnt_q           <= '0;
            sweep_idx_q     <= '0;
            failsafe_active <= 1'b0;
        end else begin
            if (accept) begin
                ptr_q <= (winner == PTR_LAST) ? '0 : winner + 1'b1;
            end
            if (!WDOG_ON || accept || expire) begin
                cnt_q <= '0;
            end else if (!failsafe_active) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (expire) begin
                failsafe_active <= 1'b1;
            end else if (accept) begin
                failsafe_active <= 1'b0;
            end
            if (state_q == ST_SWEEP) begin
                sweep_idx_q <= (sweep_idx_q == SWEEP_LAST) ? '0 : sweep_idx_q + 1'b1;
            end
        end
    end

    // Data outputs hold their last value whenever no strobe is issued.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_config_vld     <= 1'b0;
            pwm_config_channel <= '0;
            pwm_en             <= 1'b0;
            pwm_period         <= '0;
            pwm_hlevel         <= '0;
        end else if (state_q == ST_SWEEP) begin
            pwm_config_vld     <= 1'b1;
            pwm_config_channel <= sweep_idx_q;
            pwm_en             <= 1'b0;
            pwm_period         <= '0;
            pwm_hlevel         <= '0;
        end else if (accept) begin
            pwm_config_vld     <= 1'b1;
            pwm_config_channel <= req_channel[winner*PWM_CH_W +: PWM_CH_W];
            pwm_en             <= req_en[winner];
            pwm_period         <= req_period[winner*PWM_CNT_W +: PWM_CNT_W];
            pwm_hlevel         <= req_hlevel[winner*PWM_CNT_W +: PWM_CNT_W];
        end else begin
            pwm_config_vld     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pwm_cfg_arbiter.sv
// tb/tb_pwm_cfg_arbiter.sv - directed scoreboard bench for pwm_cfg_arbiter
module tb_pwm_cfg_arbiter;

    localparam int REQ_NUM = 2;
    localparam int PWM_NUM = 4;
    localparam int TIMEOUT = 20;

    logic                  clk;
    logic                  rst;
    logic [REQ_NUM-1:0]    req_vld;
    logic [REQ_NUM-1:0]    req_rdy;
    logic [8*REQ_NUM-1:0]  req_channel;
    logic [REQ_NUM-1:0]    req_en;
    logic [28*REQ_NUM-1:0] req_period;
    logic [28*REQ_NUM-1:0] req_hlevel;
    logic                  pwm_config_vld;
    logic [7:0]            pwm_config_channel;
    logic                  pwm_en;
    logic [27:0]           pwm_period;
    logic [27:0]           pwm_hlevel;
    logic                  failsafe_active;

    typedef struct {
        logic [7:0]  ch;
        logic        en;
        logic [27:0] per;
        logic [27:0] hl;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    pwm_cfg_arbiter #(
        .REQ_NUM     (REQ_NUM),
        .PWM_NUM     (PWM_NUM),
        .TIMEOUT_CYC (TIMEOUT)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .req_vld            (req_vld),
        .req_rdy            (req_rdy),
        .req_channel        (req_channel),
        .req_en             (req_en),
        .req_period         (req_period),
        .req_hlevel         (req_hlevel),
        .pwm_config_vld     (pwm_config_vld),
        .pwm_config_channel (pwm_config_channel),
        .pwm_en             (pwm_en),
        .pwm_period         (pwm_period),
        .pwm_hlevel         (pwm_hlevel),
        .failsafe_active    (failsafe_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] ch, input logic en, input logic [27:0] per, input logic [27:0] hl);
        exp_t e;
        e.ch = ch; e.en = en; e.per = per; e.hl = hl;
        q.push_back(e);
    endtask

    task automatic push_sweep();
        for (int i = 0; i < PWM_NUM; i++) push(8'(i), 1'b0, 28'd0, 28'd0);
    endtask

    // Each cycle the oldest queued strobe must appear; an empty queue means no strobe.
    task automatic check_out();
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("strobe_vld", 64'(pwm_config_vld), 64'd1);
            check("strobe_ch", 64'(pwm_config_channel), 64'(e.ch));
            check("strobe_en", 64'(pwm_en), 64'(e.en));
            check("strobe_period", 64'(pwm_period), 64'(e.per));
            check("strobe_hlevel", 64'(pwm_hlevel), 64'(e.hl));
        end else begin
            check("idle_vld", 64'(pwm_config_vld), 64'd0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic set_src(input int s, input logic v, input logic [7:0] ch, input logic en,
                           input logic [27:0] per, input logic [27:0] hl);
        req_vld[s]          = v;
        req_channel[8*s+:8] = ch;
        req_en[s]           = en;
        req_period[28*s+:28] = per;
        req_hlevel[28*s+:28] = hl;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req_vld = '0; req_channel = '0; req_en = '0; req_period = '0; req_hlevel = '0;
        q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        req_vld = '0; req_channel = '0; req_en = '0; req_period = '0; req_hlevel = '0;
        #1;
        check("rst_vld", 64'(pwm_config_vld), 64'd0);
        check("rst_ch", 64'(pwm_config_channel), 64'd0);
        check("rst_period", 64'(pwm_period), 64'd0);
        check("rst_fs", 64'(failsafe_active), 64'd0);
        check("rst_rdy", 64'(req_rdy), 64'd0);
        do_reset();

        // single request forwarded next cycle, one cycle only
        set_src(0, 1'b1, 8'd3, 1'b1, 28'd1000, 28'd250);
        #1;
        check("t1_rdy", 64'(req_rdy), 64'b01);
        push(8'd3, 1'b1, 28'd1000, 28'd250);
        tick();
        set_src(0, 1'b0, 8'd3, 1'b1, 28'd1000, 28'd250);
        tick();
        check("t1_hold_ch", 64'(pwm_config_channel), 64'd3);

        // both sources continuously: strict alternation starting at 0
        do_reset();
        for (int k = 0; k < 4; k++) begin
            set_src(0, 1'b1, 8'(k), k[0], 28'(100 + k), 28'(k));
            set_src(1, 1'b1, 8'(16 + k), ~k[0], 28'(150 + k), 28'(k + 1));
            #1;
            check("t2_rdy", 64'(req_rdy), (k % 2 == 0) ? 64'b01 : 64'b10);
            if (k % 2 == 0) push(8'(k), k[0], 28'(100 + k), 28'(k));
            else            push(8'(16 + k), ~k[0], 28'(150 + k), 28'(k + 1));
            tick();
        end
        req_vld = '0;
        tick();

        // watchdog expiry, sweep, then failsafe held with no second sweep
        do_reset();
        for (int i = 1; i <= TIMEOUT; i++) begin
            tick();
            if (i == TIMEOUT - 1) check("t3_fs_pre", 64'(failsafe_active), 64'd0);
        end
        check("t3_fs_set", 64'(failsafe_active), 64'd1);
        push_sweep();
        for (int i = 0; i < PWM_NUM; i++) tick();
        for (int i = 0; i < 2 * TIMEOUT; i++) tick();
        check("t3_fs_hold", 64'(failsafe_active), 64'd1);
        set_src(0, 1'b1, 8'h21, 1'b1, 28'd5000, 28'd10);
        #1;
        check("t3_rdy", 64'(req_rdy), 64'b01);
        push(8'h21, 1'b1, 28'd5000, 28'd10);
        tick();
        req_vld = '0;
        check("t3_fs_clear", 64'(failsafe_active), 64'd0);

        // source 1 waits out a sweep, then wins the first ARB cycle
        for (int i = 0; i < TIMEOUT; i++) tick();
        check("t5_fs_set", 64'(failsafe_active), 64'd1);
        set_src(1, 1'b1, 8'd200, 1'b1, 28'd777, 28'd333);
        push_sweep();
        for (int i = 0; i < PWM_NUM; i++) begin
            #1;
            check("t5_rdy_sweep", 64'(req_rdy), 64'b00);
            tick();
        end
        #1;
        check("t5_rdy_arb", 64'(req_rdy), 64'b10);
        push(8'd200, 1'b1, 28'd777, 28'd333);
        tick();
        req_vld = '0;
        check("t5_fs_clear", 64'(failsafe_active), 64'd0);

        // accept on the last watchdog count wins; counter restarts from zero
        do_reset();
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        set_src(0, 1'b1, 8'd9, 1'b0, 28'd42, 28'd7);
        #1;
        check("t4_rdy", 64'(req_rdy), 64'b01);
        push(8'd9, 1'b0, 28'd42, 28'd7);
        tick();
        req_vld = '0;
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        check("t4_no_sweep", 64'(failsafe_active), 64'd0);
        tick();
        check("t4_fs_fresh", 64'(failsafe_active), 64'd1);
        push_sweep();

        // reset in the middle of the sweep
        tick();
        tick();
        #1;
        rst = 1'b0;
        #1;
        check("t6_vld", 64'(pwm_config_vld), 64'd0);
        check("t6_ch", 64'(pwm_config_channel), 64'd0);
        check("t6_fs", 64'(failsafe_active), 64'd0);
        q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        check("t6_fs_pre", 64'(failsafe_active), 64'd0);
        tick();
        check("t6_fs_set", 64'(failsafe_active), 64'd1);
        push_sweep();
        for (int i = 0; i < PWM_NUM; i++) tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
